// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider control path:
// default widths, the retune sequencer states and the edge-wait timeout.
package clk_div_pkg;

  localparam int unsigned DIV_W         = 5;
  localparam int unsigned DEFAULT_RATIO = 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EDGE,
    GATE,
    APPLY,
    SETTLE
  } state_e;

  // Two full divided periods plus margin, so a stalled divider cannot hang a retune.
  function automatic logic [31:0] tmo_limit(input logic [31:0] ratio);
    return 32'd2 * ratio + 32'd2;
  endfunction

endpackage

// File: rtl/edge_fall_det.sv
// Falling-edge detector for a slow signal sampled on the local clock:
// one history flop and an AND, usable by any clock-monitor block.
module edge_fall_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_fall
);

  logic sig_q;
  logic sig_d;

  always_comb sig_d = i_sig;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) sig_q <= 1'b0;
    else          sig_q <= sig_d;
  end

  assign o_fall = sig_q & ~i_sig;

endmodule

// File: rtl/clk_div_ratio_ctrl.sv
// Ratio/enable sequencer for the integer clock divider: accepts ratio requests and
// swaps the ratio only while the divider is gated, aligned to a divided-clock fall.
module clk_div_ratio_ctrl #(
  parameter int unsigned DIV_W         = clk_div_pkg::DIV_W,
  parameter int unsigned DEFAULT_RATIO = clk_div_pkg::DEFAULT_RATIO,
  parameter int unsigned GATE_CYCLES   = 2,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             i_ref_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  input  logic [DIV_W-1:0] i_req_ratio,
  output logic             o_req_ready,
  input  logic             i_div_clk,
  output logic [DIV_W-1:0] o_div_ratio,
  output logic             o_clk_en,
  output logic             o_busy,
  output logic             o_err
);
  import clk_div_pkg::*;

  localparam int unsigned TMO_W   = DIV_W + 2;
  localparam int unsigned CNT_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   ratio_q, ratio_d;
  logic [DIV_W-1:0]   pend_q, pend_d;
  logic               clk_en_q, clk_en_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_last;
  logic               fall;
  logic               accept;

  edge_fall_det u_fall_det (
    .i_clk   (i_ref_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (i_div_clk),
    .o_fall  (fall)
  );

  assign accept   = i_req_valid & ready_q;
  assign tmo_last = TMO_W'(tmo_limit(32'(ratio_q)) - 32'd1);

  always_comb begin
    state_d  = state_q;
    ratio_d  = ratio_q;
    pend_d   = pend_q;
    clk_en_d = clk_en_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    err_d    = 1'b0;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (accept) begin
          if (i_req_ratio == '0) begin
            err_d = 1'b1;
          end else if (i_req_ratio == ratio_q) begin
            busy_d  = 1'b1;
            ready_d = 1'b0;
          end else begin
            pend_d  = i_req_ratio;
            busy_d  = 1'b1;
            ready_d = 1'b0;
            // A ratio of 1 (or an already-stopped divider) has no edge worth waiting for.
            if (ratio_q <= DIV_W'(1) || !clk_en_q) begin
              state_d  = GATE;
              clk_en_d = 1'b0;
              cnt_d    = '0;
            end else begin
              state_d = WAIT_EDGE;
              tmo_d   = '0;
            end
          end
        end
      end
      WAIT_EDGE: begin
        if (fall || tmo_q == tmo_last) begin
          state_d  = GATE;
          clk_en_d = 1'b0;
          cnt_d    = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      GATE: begin
        if (cnt_q == CNT_W'(GATE_CYCLES - 1)) begin
          state_d = APPLY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      APPLY: begin
        ratio_d = pend_q;
        state_d = SETTLE;
        cnt_d   = '0;
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d  = IDLE;
          clk_en_d = 1'b1;
          busy_d   = 1'b0;
          ready_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      ratio_q  <= DIV_W'(DEFAULT_RATIO);
      pend_q   <= '0;
      clk_en_q <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ratio_q  <= ratio_d;
      pend_q   <= pend_d;
      clk_en_q <= clk_en_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_div_ratio = ratio_q;
  assign o_clk_en    = clk_en_q;
  assign o_req_ready = ready_q;
  assign o_busy      = busy_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Directed bench for clk_div_ratio_ctrl: each task drives one scenario and checks
// cycle-by-cycle against hand-derived expectations (cycle k = k edges after acceptance).
module tb_clk_div_ratio_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [4:0] req_ratio;
  logic       req_ready;
  logic       div_clk;
  logic [4:0] div_ratio;
  logic       clk_en;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  clk_div_ratio_ctrl #(
    .DIV_W         (5),
    .DEFAULT_RATIO (1),
    .GATE_CYCLES   (2),
    .SETTLE_CYCLES (2)
  ) dut (
    .i_ref_clk   (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_ratio (req_ratio),
    .o_req_ready (req_ready),
    .i_div_clk   (div_clk),
    .o_div_ratio (div_ratio),
    .o_clk_en    (clk_en),
    .o_busy      (busy),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_ratio = '0; div_clk = 1'b0;
    tick(); tick();
    checks++; if (div_ratio !== 5'd1) begin errors++; $display("FAIL rst_ratio got=%0d exp=1", div_ratio); end
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL rst_en got=%b exp=1", clk_en); end
    rst_n = 1'b1;
    tick();
    checks++; if (div_ratio !== 5'd1) begin errors++; $display("FAIL rel_ratio got=%0d exp=1", div_ratio); end
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL rel_en got=%b exp=1", clk_en); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got=%b exp=1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rel_busy got=%b exp=0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rel_err got=%b exp=0", err); end
    $display("txn reset: ratio=%0d en=%b ready=%b busy=%b", div_ratio, clk_en, req_ready, busy);
  endtask

  // 1 -> 4: edge wait skipped, gate window is cycles 1..5, new ratio from cycle 4.
  task automatic test_skip_wait();
    int low_cnt = 0;
    logic [4:0] exp_ratio;
    req_valid = 1'b1; req_ratio = 5'd4;
    tick();
    req_valid = 1'b0; req_ratio = 5'd9;
    for (int k = 1; k <= 8; k++) begin
      exp_ratio = (k >= 4) ? 5'd4 : 5'd1;
      if (clk_en === 1'b0) low_cnt++;
      checks++; if (clk_en !== ((k <= 5) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL skip_en cyc=%0d got=%b", k, clk_en); end
      checks++; if (div_ratio !== exp_ratio) begin errors++; $display("FAIL skip_ratio cyc=%0d got=%0d exp=%0d", k, div_ratio, exp_ratio); end
      checks++; if (busy !== ((k <= 5) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL skip_busy cyc=%0d got=%b", k, busy); end
      checks++; if (req_ready !== ((k <= 5) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL skip_ready cyc=%0d got=%b", k, req_ready); end
      tick();
    end
    checks++; if (low_cnt != 5) begin errors++; $display("FAIL skip_low_len got=%0d exp=5", low_cnt); end
    $display("txn skip_wait: ratio 1->4 en_low=%0d final=%0d", low_cnt, div_ratio);
  endtask

  // 4 -> 7: divided clock falls before edge A+4, so gating starts at cycle 5.
  task automatic test_fall_edge();
    logic [4:0] exp_ratio;
    div_clk = 1'b1;
    tick();
    req_valid = 1'b1; req_ratio = 5'd7;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      exp_ratio = (k >= 8) ? 5'd7 : 5'd4;
      checks++; if (clk_en !== ((k >= 5 && k <= 9) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL fall_en cyc=%0d got=%b", k, clk_en); end
      checks++; if (div_ratio !== exp_ratio) begin errors++; $display("FAIL fall_ratio cyc=%0d got=%0d exp=%0d", k, div_ratio, exp_ratio); end
      checks++; if (busy !== ((k <= 9) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL fall_busy cyc=%0d got=%b", k, busy); end
      if (k == 4) div_clk = 1'b0;
      tick();
    end
    $display("txn fall_edge: ratio 4->7 final=%0d", div_ratio);
  endtask

  task automatic test_reject();
    req_valid = 1'b1; req_ratio = 5'd0;
    tick();
    req_valid = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL rej_err got=%b exp=1", err); end
    checks++; if (div_ratio !== 5'd7) begin errors++; $display("FAIL rej_ratio got=%0d exp=7", div_ratio); end
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL rej_en got=%b exp=1", clk_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rej_busy got=%b exp=0", busy); end
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rej_err_len got=%b exp=0", err); end
    $display("txn reject: ratio 0 refused, ratio stays %0d", div_ratio);
  endtask

  task automatic test_noop();
    req_valid = 1'b1; req_ratio = 5'd7;
    tick();
    req_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL noop_busy1 got=%b exp=1", busy); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL noop_ready1 got=%b exp=0", req_ready); end
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL noop_en1 got=%b exp=1", clk_en); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL noop_err got=%b exp=0", err); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noop_busy2 got=%b exp=0", busy); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL noop_ready2 got=%b exp=1", req_ready); end
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL noop_en2 got=%b exp=1", clk_en); end
    checks++; if (div_ratio !== 5'd7) begin errors++; $display("FAIL noop_ratio got=%0d exp=7", div_ratio); end
    $display("txn noop: ratio 7 re-requested, busy one cycle");
  endtask

  // Divided clock held flat: timeout 2*old+2 cycles, gating from cycle 2*old+3.
  task automatic test_timeout();
    logic [4:0] olds [2] = '{5'd7, 5'd5};
    logic [4:0] news [2] = '{5'd5, 5'd3};
    logic       lvls [2] = '{1'b0, 1'b1};
    int s;
    logic [4:0] exp_ratio;
    for (int r = 0; r < 2; r++) begin
      s = 2 * int'(olds[r]) + 3;
      div_clk = lvls[r];
      tick();
      req_valid = 1'b1; req_ratio = news[r];
      tick();
      req_valid = 1'b0;
      for (int k = 1; k <= s + 6; k++) begin
        exp_ratio = (k >= s + 3) ? news[r] : olds[r];
        checks++; if (clk_en !== ((k >= s && k <= s + 4) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL tmo_en run=%0d cyc=%0d got=%b", r, k, clk_en); end
        checks++; if (div_ratio !== exp_ratio) begin errors++; $display("FAIL tmo_ratio run=%0d cyc=%0d got=%0d exp=%0d", r, k, div_ratio, exp_ratio); end
        checks++; if (busy !== ((k <= s + 4) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL tmo_busy run=%0d cyc=%0d got=%b", r, k, busy); end
        tick();
      end
      $display("txn timeout: ratio %0d->%0d final=%0d", olds[r], news[r], div_ratio);
    end
  endtask

  // Abort 3 -> 6 in GATE with a second request pending; reset restores defaults.
  task automatic test_reset_mid_gate();
    req_valid = 1'b1; req_ratio = 5'd6;
    tick();
    req_ratio = 5'd2; div_clk = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got=%b exp=0", req_ready); end
    tick();
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL mid_gate_en got=%b exp=0", clk_en); end
    checks++; if (div_ratio !== 5'd3) begin errors++; $display("FAIL mid_gate_ratio got=%0d exp=3", div_ratio); end
    rst_n = 1'b0; req_valid = 1'b0;
    tick();
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL mid_rst_en got=%b exp=1", clk_en); end
    checks++; if (div_ratio !== 5'd1) begin errors++; $display("FAIL mid_rst_ratio got=%0d exp=1", div_ratio); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got=%b exp=1", req_ready); end
    rst_n = 1'b1;
    tick();
    checks++; if (div_ratio !== 5'd1) begin errors++; $display("FAIL mid_post_ratio got=%0d exp=1", div_ratio); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_post_busy got=%b exp=0", busy); end
    $display("txn reset_mid_gate: aborted 3->6, ratio=%0d", div_ratio);
  endtask

  // 1 -> 4 with a competing request held valid throughout; it must be ignored while busy.
  task automatic test_back_to_back();
    req_valid = 1'b1; req_ratio = 5'd4;
    tick();
    req_ratio = 5'd2;
    for (int k = 1; k <= 6; k++) begin
      checks++; if (req_ready !== ((k <= 5) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL b2b_ready cyc=%0d got=%b", k, req_ready); end
      if (k >= 4) begin
        checks++; if (div_ratio !== 5'd4) begin errors++; $display("FAIL b2b_ratio cyc=%0d got=%0d exp=4", k, div_ratio); end
      end
      if (k < 6) tick();
    end
    req_valid = 1'b0;
    tick();
    checks++; if (div_ratio !== 5'd4) begin errors++; $display("FAIL b2b_final_ratio got=%0d exp=4", div_ratio); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_final_busy got=%b exp=0", busy); end
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL b2b_final_en got=%b exp=1", clk_en); end
    $display("txn back_to_back: ratio 1->4, held request ignored, ratio=%0d", div_ratio);
  endtask

  initial begin
    test_reset();
    test_skip_wait();
    test_fall_edge();
    test_reject();
    test_noop();
    test_timeout();
    test_reset_mid_gate();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
